// File: rtl/vdp_cpu_vram_port.sv
// rtl/vdp_cpu_vram_port.sv - CPU-side VDP port 0/1 front end for VRAM access
//
// Purpose:
//   Decodes the two-byte control-port sequence into VDP register writes or
//   VRAM address loads. Turns data-port reads and writes into toggle-handshake
//   requests for the VRAM access arbiter. Keeps a one-byte read-ahead buffer
//   filled from the arbiter's read results.
//
// Ports:
//   CLK21M, RESET               clock, asynchronous active-high reset
//   REQ, WRT, ADR, DBO          CPU access strobe, direction, port select, write data
//   DBI                         CPU read data (data port)
//   DOTSTATE                    dot phase; read results are captured in phase 01
//   REG_R14                     VRAM address bits 16:14
//   PRAMDBI                     VRAM read byte
//   VDPVRAMACCESSDATA           byte for the arbiter to write
//   VDPVRAMACCESSADDRTMP        address for the arbiter to load
//   VDPVRAMADDRSETREQ/ACK       address-load toggle pair
//   VDPVRAMWRREQ/ACK            write toggle pair
//   VDPVRAMRDREQ/ACK            read/prefetch toggle pair
//   VDPVRAMREADINGR/A           read-issued / read-captured toggle pair
//   REG_WR_STB, _NUM, _DATA     one-cycle register write pulse with number and value
//   CPU_BUSY                    a VRAM request is outstanding or held

module vdp_cpu_vram_port (
  input  logic        CLK21M,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WRT,
  input  logic [1:0]  ADR,
  input  logic [7:0]  DBO,
  output logic [7:0]  DBI,
  input  logic [1:0]  DOTSTATE,
  input  logic [2:0]  REG_R14,
  input  logic [7:0]  PRAMDBI,
  output logic [7:0]  VDPVRAMACCESSDATA,
  output logic [16:0] VDPVRAMACCESSADDRTMP,
  output logic        VDPVRAMADDRSETREQ,
  input  logic        VDPVRAMADDRSETACK,
  output logic        VDPVRAMWRREQ,
  input  logic        VDPVRAMWRACK,
  output logic        VDPVRAMRDREQ,
  input  logic        VDPVRAMRDACK,
  input  logic        VDPVRAMREADINGR,
  output logic        VDPVRAMREADINGA,
  output logic        REG_WR_STB,
  output logic [5:0]  REG_WR_NUM,
  output logic [7:0]  REG_WR_DATA,
  output logic        CPU_BUSY
);

  // control-port byte sequencing
  logic       first_flag;
  logic [7:0] first_latch;

  // read-ahead buffer
  logic [7:0] rd_buf;

  // single-entry holding registers, one per request type
  logic       wr_hold_valid;
  logic [7:0] wr_hold_data;
  logic       rd_hold_valid;
  logic       as_hold_valid;

  // decoded CPU accesses
  logic data_wr, data_rd, ctl_wr, ctl_rd;
  logic second_byte, reg_write, addr_set, addr_set_rd, new_rd;

  // handshake status
  logic wr_pend, rd_pend, as_pend;
  logic wr_issue_hold, rd_issue_hold, as_issue_hold;
  logic capture;

  assign data_wr     = REQ &  WRT & (ADR == 2'b00);
  assign data_rd     = REQ & ~WRT & (ADR == 2'b00);
  assign ctl_wr      = REQ &  WRT & (ADR == 2'b01);
  assign ctl_rd      = REQ & ~WRT & (ADR == 2'b01);

  assign second_byte = ctl_wr & first_flag;
  assign reg_write   = second_byte &  DBO[7];
  assign addr_set    = second_byte & ~DBO[7];
  assign addr_set_rd = addr_set & ~DBO[6];
  // a read-mode address set prefetches through the same read channel
  assign new_rd      = data_rd | addr_set_rd;

  assign wr_pend = VDPVRAMWRREQ      ^ VDPVRAMWRACK;
  assign rd_pend = VDPVRAMRDREQ      ^ VDPVRAMRDACK;
  assign as_pend = VDPVRAMADDRSETREQ ^ VDPVRAMADDRSETACK;

  // a held request goes out as soon as its channel has been acknowledged
  assign wr_issue_hold = wr_hold_valid & ~wr_pend;
  assign rd_issue_hold = rd_hold_valid & ~rd_pend;
  assign as_issue_hold = as_hold_valid & ~as_pend;

  assign capture = (VDPVRAMREADINGR != VDPVRAMREADINGA) & (DOTSTATE == 2'b01);

  assign CPU_BUSY = wr_pend | rd_pend | as_pend |
                    wr_hold_valid | rd_hold_valid | as_hold_valid;

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      DBI                  <= 8'h00;
      VDPVRAMACCESSDATA    <= 8'h00;
      VDPVRAMACCESSADDRTMP <= 17'h0;
      VDPVRAMADDRSETREQ    <= 1'b0;
      VDPVRAMWRREQ         <= 1'b0;
      VDPVRAMRDREQ         <= 1'b0;
      VDPVRAMREADINGA      <= 1'b0;
      REG_WR_STB           <= 1'b0;
      REG_WR_NUM           <= 6'h0;
      REG_WR_DATA          <= 8'h00;
      first_flag           <= 1'b0;
      first_latch          <= 8'h00;
      rd_buf               <= 8'h00;
      wr_hold_valid        <= 1'b0;
      wr_hold_data         <= 8'h00;
      rd_hold_valid        <= 1'b0;
      as_hold_valid        <= 1'b0;
    end else begin
      REG_WR_STB <= 1'b0;

      // any other port 0/1 access resynchronises the byte pairing
      if (ctl_wr) begin
        if (!first_flag) begin
          first_latch <= DBO;
          first_flag  <= 1'b1;
        end else begin
          first_flag  <= 1'b0;
        end
      end else if (ctl_rd | data_wr | data_rd) begin
        first_flag <= 1'b0;
      end

      if (reg_write) begin
        REG_WR_STB  <= 1'b1;
        REG_WR_NUM  <= DBO[5:0];
        REG_WR_DATA <= first_latch;
      end

      if (addr_set) begin
        VDPVRAMACCESSADDRTMP <= {REG_R14, DBO[5:0], first_latch};
      end

      // address-load channel; a held load picks up the latest ADDRTMP
      if (as_issue_hold) begin
        VDPVRAMADDRSETREQ <= ~VDPVRAMADDRSETREQ;
        as_hold_valid     <= 1'b0;
      end else if (addr_set & ~as_pend) begin
        VDPVRAMADDRSETREQ <= ~VDPVRAMADDRSETREQ;
      end
      if (addr_set & (as_pend | as_hold_valid)) begin
        as_hold_valid <= 1'b1;
      end

      // write channel; ACCESSDATA only changes when a toggle goes out so the
      // arbiter never sees the byte move under a pending request
      if (wr_issue_hold) begin
        VDPVRAMWRREQ      <= ~VDPVRAMWRREQ;
        VDPVRAMACCESSDATA <= wr_hold_data;
        wr_hold_valid     <= 1'b0;
      end else if (data_wr & ~wr_pend) begin
        VDPVRAMWRREQ      <= ~VDPVRAMWRREQ;
        VDPVRAMACCESSDATA <= DBO;
      end
      // an occupied holder is overwritten so the newest byte wins
      if (data_wr & (wr_pend | wr_hold_valid)) begin
        wr_hold_data  <= DBO;
        wr_hold_valid <= 1'b1;
      end

      // read / prefetch channel
      if (rd_issue_hold) begin
        VDPVRAMRDREQ  <= ~VDPVRAMRDREQ;
        rd_hold_valid <= 1'b0;
      end else if (new_rd & ~rd_pend) begin
        VDPVRAMRDREQ <= ~VDPVRAMRDREQ;
      end
      if (new_rd & (rd_pend | rd_hold_valid)) begin
        rd_hold_valid <= 1'b1;
      end

      // the CPU gets the buffer as it stood before any same-cycle capture
      if (data_rd) begin
        DBI <= rd_buf;
      end

      if (capture) begin
        rd_buf          <= PRAMDBI;
        VDPVRAMREADINGA <= VDPVRAMREADINGR;
      end
    end
  end

endmodule
